// File: rtl/ped_crossing_pkg.sv
// ped_crossing_pkg: state encoding, counter width and default phase durations for ped_crossing.
package ped_crossing_pkg;

    localparam int CNT_W          = 8;
    localparam int GREEN_MIN_DEF  = 16;
    localparam int AMBER_CYC_DEF  = 4;
    localparam int WALK_CYC_DEF   = 12;
    localparam int RA_CYC_DEF     = 2;
    localparam int FLASH_CYC_DEF  = 8;
    localparam int FLASH_HALF_DEF = 2;

    typedef enum logic [2:0] {
        S_GREEN     = 3'd0,
        S_AMBER     = 3'd1,
        S_RED       = 3'd2,
        S_RED_AMBER = 3'd3
`ifdef PED_FLASH_EN
        ,
        S_FLASH     = 3'd4
`endif
    } state_t;

    function automatic logic [CNT_W-1:0] dur_m1(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/ped_crossing_sync.sv
// sync2: two-flop synchroniser for the asynchronous push-button.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d, s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/ped_crossing.sv
// ped_crossing: pedestrian crossing controller (green/amber/red-walk/red-amber).
// Define PED_FLASH_EN to replace RED_AMBER with a flashing amber/walk phase.
module ped_crossing
    import ped_crossing_pkg::*;
#(
    parameter int GREEN_MIN  = GREEN_MIN_DEF,
    parameter int AMBER_CYC  = AMBER_CYC_DEF,
    parameter int WALK_CYC   = WALK_CYC_DEF,
    parameter int RA_CYC     = RA_CYC_DEF,
    parameter int FLASH_CYC  = FLASH_CYC_DEF,
    parameter int FLASH_HALF = FLASH_HALF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic r,
    output logic a,
    output logic g,
    output logic walk,
    output logic wait_lamp
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             btn_s, done, blocked;

    sync2 u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (button),
        .q    (btn_s)
    );

    assign done = cnt_q == '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = done ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            S_GREEN: if (done && req_q) begin
                state_d = S_AMBER;
                cnt_d   = dur_m1(AMBER_CYC);
            end
            S_AMBER: if (done) begin
                state_d = S_RED;
                cnt_d   = dur_m1(WALK_CYC);
            end
`ifdef PED_FLASH_EN
            S_RED: if (done) begin
                state_d = S_FLASH;
                cnt_d   = dur_m1(FLASH_CYC);
            end
            S_FLASH: if (done) begin
                state_d = S_GREEN;
                cnt_d   = dur_m1(GREEN_MIN);
            end
`else
            S_RED: if (done) begin
                state_d = S_RED_AMBER;
                cnt_d   = dur_m1(RA_CYC);
            end
            S_RED_AMBER: if (done) begin
                state_d = S_GREEN;
                cnt_d   = dur_m1(GREEN_MIN);
            end
`endif
            default: begin
                state_d = S_GREEN;
                cnt_d   = dur_m1(GREEN_MIN);
            end
        endcase
    end

`ifdef PED_FLASH_EN
    assign blocked = state_q == S_RED || state_q == S_FLASH;
`else
    assign blocked = state_q == S_RED;
`endif

    // Entering (or sitting in) RED clears the request, beating a same-cycle press.
    always_comb begin
        req_d = req_q;
        if (state_d == S_RED) req_d = 1'b0;
        else if (!blocked) req_d = req_q | btn_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_GREEN;
            cnt_q   <= dur_m1(GREEN_MIN);
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

`ifdef PED_FLASH_EN
    logic             flash_on_q, flash_on_d;
    logic [CNT_W-1:0] half_q, half_d;

    always_comb begin
        flash_on_d = flash_on_q;
        half_d     = half_q;
        if (state_d == S_FLASH && state_q != S_FLASH) begin
            flash_on_d = 1'b1;
            half_d     = dur_m1(FLASH_HALF);
        end else if (state_q == S_FLASH) begin
            flash_on_d = half_q == '0 ? ~flash_on_q : flash_on_q;
            half_d     = half_q == '0 ? dur_m1(FLASH_HALF) : half_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_on_q <= 1'b0;
            half_q     <= '0;
        end else begin
            flash_on_q <= flash_on_d;
            half_q     <= half_d;
        end
    end

    assign a    = state_q == S_AMBER || (state_q == S_FLASH && flash_on_q);
    assign walk = state_q == S_RED || (state_q == S_FLASH && flash_on_q);
`else
    assign a    = state_q == S_AMBER || state_q == S_RED_AMBER;
    assign walk = state_q == S_RED;
`endif

    assign g         = state_q == S_GREEN;
    assign r         = state_q == S_RED || state_q == S_RED_AMBER;
    assign wait_lamp = req_q;

endmodule
